// File: rtl/stream_dilation3x3.sv
// Streaming 3x3 binary dilation: thresholds each pixel to one bit, keeps two
// 1-bit line buffers and emits 255/0 for every valid-region window centre.
module stream_dilation3x3 #(
   parameter int         IMG_W  = 64,
   parameter int         IMG_H  = 64,
   parameter logic [7:0] THRESH = 8'd127
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_pixel,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_pixel,
   output logic       out_last
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [IMG_W-1:0] r_lb_prev;    // bits of row r-1, indexed by column
   logic [IMG_W-1:0] r_lb_prev2;   // bits of row r-2, indexed by column
   logic [2:0]       r_win_c1;     // column c-1 of the window (rows r-2..r)
   logic [2:0]       r_win_c2;     // column c-2 of the window
   logic             r_out_valid;
   logic [7:0]       r_out_pixel;
   logic             r_out_last;

   logic       w_accept;
   logic       w_bit;
   logic [2:0] w_new_col;
   logic       w_hit;
   logic       w_emit;
   logic       w_col_end;
   logic       w_row_end;

   assign in_ready  = ~r_out_valid | out_ready;
   assign w_accept  = in_valid & in_ready;
   assign w_bit     = (in_pixel > THRESH);
   assign w_new_col = {r_lb_prev2[r_col], r_lb_prev[r_col], w_bit};
   // The incoming column plus the two registered ones form the full 3x3 window.
   assign w_hit     = (|w_new_col) | (|r_win_c1) | (|r_win_c2);
   assign w_emit    = (r_row >= RW'(2)) && (r_col >= CW'(2));
   assign w_col_end = (r_col == CW'(IMG_W - 1));
   assign w_row_end = (r_row == RW'(IMG_H - 1));

   assign out_valid = r_out_valid;
   assign out_pixel = r_out_pixel;
   assign out_last  = r_out_last;

   // NOTE: the line buffers are storage, not control state; they carry no reset
   // because every entry is rewritten by rows 0/1 before any output reads it.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb_prev[r_col]  <= w_bit;
         r_lb_prev2[r_col] <= r_lb_prev[r_col];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col    <= '0;
         r_row    <= '0;
         r_win_c1 <= '0;
         r_win_c2 <= '0;
      end else if (w_accept) begin
         r_win_c1 <= w_new_col;
         r_win_c2 <= r_win_c1;
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_pixel <= 8'd0;
         r_out_last  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= w_emit;
         r_out_pixel <= (w_emit && w_hit) ? 8'd255 : 8'd0;
         r_out_last  <= w_emit && w_col_end && w_row_end;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_dilation3x3.sv
// Directed bench for stream_dilation3x3 on a 5x5 image with hand-derived
// expected output sequences.
module tb_stream_dilation3x3;

   localparam int W = 5;
   localparam int H = 5;
   localparam int N = W * H;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       in_valid  = 1'b0;
   logic [7:0] in_pixel  = 8'd0;
   logic       out_ready = 1'b1;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_pixel;
   logic       out_last;

   always #5 clk = ~clk;

   stream_dilation3x3 #(.IMG_W(W), .IMG_H(H), .THRESH(8'd127)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pixel (out_pixel),
      .out_last  (out_last)
   );

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0] tx_q[$];
   logic [7:0] out_q[$];
   logic       last_q[$];
   logic [7:0] exp_q[$];
   logic       exp_last_q[$];

   int acc_count;
   int first_valid_acc;
   int stall_req;
   int steps;
   bit seen_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      out_q.delete();
      last_q.delete();
      exp_q.delete();
      exp_last_q.delete();
      tx_q.delete();
      acc_count  = 0;
      seen_valid = 1'b0;
      stall_req  = 0;
   endtask

   // One clock: drive inputs after the falling edge, sample just before the rising edge.
   task automatic step(input logic iv, input logic [7:0] px, output logic acc);
      @(negedge clk);
      in_valid = iv;
      in_pixel = px;
      #1;
      if (out_valid && !seen_valid) begin
         seen_valid      = 1'b1;
         first_valid_acc = acc_count;
      end
      if (stall_req > 0 && out_valid) begin
         out_ready = 1'b0;
         stall_req--;
      end else begin
         out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
         check("stall_in_ready", 32'(in_ready), 0);
         check("stall_hold_px", 32'(out_pixel), 255);
         check("stall_hold_last", 32'(out_last), 0);
      end
      if (out_valid && out_ready) begin
         out_q.push_back(out_pixel);
         last_q.push_back(out_last);
      end
      acc = iv && in_ready;
      @(posedge clk);
   endtask

   task automatic feed(input string tag);
      int   idx = 0;
      int   budget = 0;
      logic acc;
      steps = 0;
      while (idx < tx_q.size() && budget < 400) begin
         step(1'b1, tx_q[idx], acc);
         steps++;
         budget++;
         if (acc) begin
            idx++;
            acc_count++;
         end
      end
      check({tag, "_fed"}, idx, tx_q.size());
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, acc);
   endtask

   task automatic load_frame(input logic [7:0] bg, input int pos, input logic [7:0] v);
      for (int i = 0; i < N; i++) tx_q.push_back((i == pos) ? v : bg);
   endtask

   task automatic exp_fill(input logic [7:0] v);
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(v);
         exp_last_q.push_back(i == 8);
      end
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, "_count"}, out_q.size(), exp_q.size());
      n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_px%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(exp_last_q[i]));
      end
   endtask

   initial begin
      do_reset();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_pixel", 32'(out_pixel), 0);
      check("rst_in_ready", 32'(in_ready), 1);

      // 1: all-zero frame, latency of first output
      do_reset();
      load_frame(8'd0, -1, 8'd0);
      exp_fill(8'd0);
      feed("t1");
      compare("t1");
      check("t1_first_valid_after", first_valid_acc, 13);

      // 2: single hot centre pixel lights every window
      do_reset();
      load_frame(8'd0, 2 * W + 2, 8'd200);
      exp_fill(8'd255);
      feed("t2");
      compare("t2");

      // 3: corner pixel just above and at threshold
      do_reset();
      load_frame(8'd0, 0, 8'd128);
      exp_fill(8'd0);
      exp_q[0] = 8'd255;
      feed("t3a");
      compare("t3a");
      do_reset();
      load_frame(8'd0, 0, 8'd127);
      exp_fill(8'd0);
      feed("t3b");
      compare("t3b");

      // 4: back-pressure for 5 cycles on the first output
      do_reset();
      load_frame(8'd0, 2 * W + 2, 8'd200);
      exp_fill(8'd255);
      stall_req = 5;
      feed("t4");
      compare("t4");
      check("t4_stalls_used", stall_req, 0);

      // 5: mid-frame reset after 12 pixels, then a fresh frame
      do_reset();
      for (int i = 0; i < 12; i++) tx_q.push_back(8'd255);
      feed("t5_abort");
      check("t5_abort_outputs", out_q.size(), 0);
      do_reset();
      check("t5_rst_out_valid", 32'(out_valid), 0);
      check("t5_rst_in_ready", 32'(in_ready), 1);
      load_frame(8'd0, 4 * W + 4, 8'd255);
      exp_fill(8'd0);
      exp_q[8] = 8'd255;
      feed("t5");
      compare("t5");

      // 6: two frames back-to-back at full rate
      do_reset();
      load_frame(8'd255, -1, 8'd0);
      load_frame(8'd0, -1, 8'd0);
      exp_fill(8'd255);
      exp_fill(8'd0);
      feed("t6");
      compare("t6");
      check("t6_cycles", steps, 2 * N);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
